// File: rtl/jtvigil_scr2_slot.sv
// Scroll-2 ROM responder with a tag cache in front of a 16-bit SDRAM slot.
// Define JTVIGIL_SCR2_PREFETCH_EN for two entries plus next-word prefetch.
module jtvigil_scr2_slot #(
  parameter logic [21:0] OFFSET = 22'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rom_cs,
  input  logic [17:0] rom_addr,
  output logic [31:0] rom_data,
  output logic        rom_ok,
  output logic [21:0] sdram_addr,
  output logic        sdram_req,
  input  logic        sdram_ack,
  input  logic        data_dst,
  input  logic        data_rdy,
  input  logic [15:0] sdram_din
);

`ifdef JTVIGIL_SCR2_PREFETCH_EN
  localparam int N = 2;
`else
  localparam int N = 1;
`endif

  typedef enum logic [1:0] {
    IDLE, REQ, BEAT0, BEAT1
  } state_t;

  state_t state, state_nx;

  logic [N-1:0] valid;
  logic [15:0]  tag  [N];
  logic [31:0]  data [N];

  logic [15:0] cur_tag;
  logic [15:0] fill_tag;
  logic [15:0] fill_lo;
  logic [15:0] new_tag;
  logic        hit;
  logic [31:0] hit_data;
  logic        start_dem;
  logic        start_pf;
  logic        store_lo;
  logic        fill_done;

`ifdef JTVIGIL_SCR2_PREFETCH_EN
  logic        rr;
  logic        is_pf;
  logic        pf_pending;
  logic [15:0] pf_tag;
  logic        pf_hit;
  logic        pf_skip;
`endif

  assign cur_tag = rom_addr[17:2];

  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int i = 0; i < N; i++) begin
      if (rom_cs && valid[i] && tag[i] == cur_tag) begin
        hit      = 1'b1;
        hit_data = data[i];
      end
    end
  end

`ifdef JTVIGIL_SCR2_PREFETCH_EN
  always_comb begin
    pf_hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (valid[i] && tag[i] == pf_tag) pf_hit = 1'b1;
    end
  end

  assign new_tag = start_pf ? pf_tag : cur_tag;
`else
  assign new_tag = cur_tag;
`endif

  always_comb begin
    state_nx  = state;
    start_dem = 1'b0;
    start_pf  = 1'b0;
    store_lo  = 1'b0;
    fill_done = 1'b0;
`ifdef JTVIGIL_SCR2_PREFETCH_EN
    pf_skip   = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (rom_cs && !hit) begin
          start_dem = 1'b1;
          state_nx  = REQ;
        end
`ifdef JTVIGIL_SCR2_PREFETCH_EN
        else if (pf_pending) begin
          if (pf_hit) begin
            pf_skip = 1'b1;
          end else begin
            start_pf = 1'b1;
            state_nx = REQ;
          end
        end
`endif
      end
      REQ: begin
        if (sdram_ack) state_nx = BEAT0;
      end
      BEAT0: begin
        if (data_dst) begin
          store_lo = 1'b1;
          state_nx = BEAT1;
        end
      end
      BEAT1: begin
        if (data_dst) begin
          fill_done = 1'b1;
          state_nx  = IDLE;
        end else if (data_rdy) begin
          // burst ended early: the partial fill is dropped
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      valid      <= '0;
      rom_ok     <= 1'b0;
      rom_data   <= '0;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      fill_tag   <= '0;
      fill_lo    <= '0;
`ifdef JTVIGIL_SCR2_PREFETCH_EN
      rr         <= 1'b0;
      is_pf      <= 1'b0;
      pf_pending <= 1'b0;
      pf_tag     <= '0;
`endif
    end else begin
      state  <= state_nx;
      rom_ok <= hit;
      if (hit) rom_data <= hit_data;
      if (start_dem || start_pf) begin
        fill_tag   <= new_tag;
        sdram_addr <= OFFSET + {5'd0, new_tag, 1'b0};
        sdram_req  <= 1'b1;
      end
      if (state == REQ && sdram_ack) sdram_req <= 1'b0;
      if (store_lo) fill_lo <= sdram_din;
`ifdef JTVIGIL_SCR2_PREFETCH_EN
      if (start_dem || start_pf || pf_skip) pf_pending <= 1'b0;
      if (start_dem || start_pf) is_pf <= start_pf;
      if (fill_done) begin
        valid[rr] <= 1'b1;
        tag[rr]   <= fill_tag;
        data[rr]  <= {sdram_din, fill_lo};
        rr        <= ~rr;
        if (!is_pf) begin
          pf_pending <= 1'b1;
          pf_tag     <= fill_tag + 16'd1;
        end
      end
`else
      if (fill_done) begin
        valid[0] <= 1'b1;
        tag[0]   <= fill_tag;
        data[0]  <= {sdram_din, fill_lo};
      end
`endif
    end
  end

endmodule

// File: tb/tb_jtvigil_scr2_slot.sv
// Directed bench for the scroll-2 ROM slot.
// Second instance exercises address wrap-around at the top of SDRAM.
module tb_jtvigil_scr2_slot;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_cs;
  logic [17:0] rom_addr;
  logic [31:0] rom_data;
  logic        rom_ok;
  logic [21:0] sdram_addr;
  logic        sdram_req;
  logic        sdram_ack;
  logic        data_dst;
  logic        data_rdy;
  logic [15:0] sdram_din;

  logic        rom_cs2;
  logic [17:0] rom_addr2;
  logic [31:0] rom_data2;
  logic        rom_ok2;
  logic [21:0] sdram_addr2;
  logic        sdram_req2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jtvigil_scr2_slot #(.OFFSET(22'h100000)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .rom_cs    (rom_cs),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .rom_ok    (rom_ok),
    .sdram_addr(sdram_addr),
    .sdram_req (sdram_req),
    .sdram_ack (sdram_ack),
    .data_dst  (data_dst),
    .data_rdy  (data_rdy),
    .sdram_din (sdram_din)
  );

  jtvigil_scr2_slot #(.OFFSET(22'h3FFFF0)) u_wrap (
    .clk       (clk),
    .rst       (rst),
    .rom_cs    (rom_cs2),
    .rom_addr  (rom_addr2),
    .rom_data  (rom_data2),
    .rom_ok    (rom_ok2),
    .sdram_addr(sdram_addr2),
    .sdram_req (sdram_req2),
    .sdram_ack (1'b0),
    .data_dst  (1'b0),
    .data_rdy  (1'b0),
    .sdram_din (16'h0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic serve(input logic [15:0] lo, input logic [15:0] hi);
    int n;
    n = 0;
    while (!sdram_req && n < 8) begin
      tick();
      n++;
    end
    checks++;
    if (sdram_req !== 1'b1) begin
      $display("FAIL serve_req: sdram_req=%b required 1", sdram_req);
      errors++;
    end
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    data_dst  = 1'b1;
    sdram_din = lo;
    tick();
    sdram_din = hi;
    data_rdy  = 1'b1;
    tick();
    data_dst  = 1'b0;
    data_rdy  = 1'b0;
    sdram_din = '0;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 4;
    if (rom_ok !== 1'b0) begin
      $display("FAIL rst_ok: got %b want 0", rom_ok); errors++;
    end
    if (rom_data !== 32'h0) begin
      $display("FAIL rst_data: got %h want 0", rom_data); errors++;
    end
    if (sdram_req !== 1'b0) begin
      $display("FAIL rst_req: got %b want 0", sdram_req); errors++;
    end
    if (sdram_addr !== 22'h0) begin
      $display("FAIL rst_addr: got %h want 0", sdram_addr); errors++;
    end
  endtask

  task automatic test_fill();
    rom_cs   = 1'b1;
    rom_addr = 18'h00010;
    tick();
    checks += 2;
    if (sdram_req !== 1'b1) begin
      $display("FAIL fill_req: got %b want 1", sdram_req); errors++;
    end
    if (sdram_addr !== 22'h100008) begin
      $display("FAIL fill_addr: got %h want 100008", sdram_addr); errors++;
    end
    serve(16'h3412, 16'h7856);
    checks++;
    if (rom_ok !== 1'b0) begin
      $display("FAIL fill_ok_early: got %b want 0", rom_ok); errors++;
    end
    tick();
    checks += 2;
    if (rom_ok !== 1'b1) begin
      $display("FAIL fill_ok: got %b want 1", rom_ok); errors++;
    end
    if (rom_data !== 32'h78563412) begin
      $display("FAIL fill_data: got %h want 78563412", rom_data); errors++;
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (rom_ok !== 1'b1 || rom_data !== 32'h78563412) begin
        $display("FAIL hold_ok[%0d]: ok=%b data=%h want 1/78563412",
                 i, rom_ok, rom_data);
        errors++;
      end
`ifndef JTVIGIL_SCR2_PREFETCH_EN
      checks++;
      if (sdram_req !== 1'b0) begin
        $display("FAIL hold_req[%0d]: got %b want 0", i, sdram_req);
        errors++;
      end
`endif
    end
  endtask

  task automatic test_addr_change();
    rom_cs = 1'b0;
    do_reset();
    rom_cs   = 1'b1;
    rom_addr = 18'h00010;
    tick();
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    rom_addr  = 18'h00014;
    data_dst  = 1'b1;
    sdram_din = 16'h1111;
    tick();
    sdram_din = 16'h2222;
    data_rdy  = 1'b1;
    tick();
    data_dst = 1'b0;
    data_rdy = 1'b0;
    checks++;
    if (rom_ok !== 1'b0) begin
      $display("FAIL chg_ok0: got %b want 0", rom_ok); errors++;
    end
    tick();
    checks += 3;
    if (sdram_req !== 1'b1) begin
      $display("FAIL chg_req: got %b want 1", sdram_req); errors++;
    end
    if (sdram_addr !== 22'h10000A) begin
      $display("FAIL chg_addr: got %h want 10000a", sdram_addr); errors++;
    end
    if (rom_ok !== 1'b0) begin
      $display("FAIL chg_ok1: got %b want 0", rom_ok); errors++;
    end
    serve(16'hBEEF, 16'hDEAD);
    tick();
    checks += 2;
    if (rom_ok !== 1'b1) begin
      $display("FAIL chg_ok2: got %b want 1", rom_ok); errors++;
    end
    if (rom_data !== 32'hDEADBEEF) begin
      $display("FAIL chg_data: got %h want deadbeef", rom_data); errors++;
    end
  endtask

  task automatic test_reset_midfetch();
    rom_cs = 1'b0;
    do_reset();
    rom_cs   = 1'b1;
    rom_addr = 18'h00020;
    tick();
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    data_dst  = 1'b1;
    sdram_din = 16'hAAAA;
    tick();
    data_dst = 1'b0;
    rom_cs   = 1'b0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    checks += 2;
    if (sdram_req !== 1'b0) begin
      $display("FAIL rmf_req: got %b want 0", sdram_req); errors++;
    end
    if (rom_ok !== 1'b0) begin
      $display("FAIL rmf_ok: got %b want 0", rom_ok); errors++;
    end
    data_dst  = 1'b1;
    data_rdy  = 1'b1;
    sdram_din = 16'hBBBB;
    tick();
    data_dst = 1'b0;
    data_rdy = 1'b0;
    rom_cs   = 1'b1;
    tick();
    checks += 3;
    if (rom_ok !== 1'b0) begin
      $display("FAIL rmf_late_ok: got %b want 0", rom_ok); errors++;
    end
    if (sdram_req !== 1'b1) begin
      $display("FAIL rmf_refetch: got %b want 1", sdram_req); errors++;
    end
    if (sdram_addr !== 22'h100010) begin
      $display("FAIL rmf_addr: got %h want 100010", sdram_addr); errors++;
    end
    serve(16'h5678, 16'h1234);
    tick();
    checks += 2;
    if (rom_ok !== 1'b1) begin
      $display("FAIL rmf_ok2: got %b want 1", rom_ok); errors++;
    end
    if (rom_data !== 32'h12345678) begin
      $display("FAIL rmf_data: got %h want 12345678", rom_data); errors++;
    end
  endtask

  task automatic test_wrap();
    rom_cs2   = 1'b1;
    rom_addr2 = 18'h3FFFC;
    tick();
    checks += 2;
    if (sdram_req2 !== 1'b1) begin
      $display("FAIL wrap_req: got %b want 1", sdram_req2); errors++;
    end
    if (sdram_addr2 !== 22'h01FFEE) begin
      $display("FAIL wrap_addr: got %h want 01ffee", sdram_addr2); errors++;
    end
  endtask

`ifdef JTVIGIL_SCR2_PREFETCH_EN
  task automatic test_prefetch();
    rom_cs = 1'b0;
    do_reset();
    rom_cs   = 1'b1;
    rom_addr = 18'h00010;
    tick();
    serve(16'h1111, 16'h2222);
    tick();
    checks += 2;
    if (sdram_req !== 1'b1) begin
      $display("FAIL pf_req: got %b want 1", sdram_req); errors++;
    end
    if (sdram_addr !== 22'h10000A) begin
      $display("FAIL pf_addr: got %h want 10000a", sdram_addr); errors++;
    end
    serve(16'h3333, 16'h4444);
    tick();
    rom_addr = 18'h00014;
    tick();
    checks += 3;
    if (rom_ok !== 1'b1) begin
      $display("FAIL pf_ok: got %b want 1", rom_ok); errors++;
    end
    if (rom_data !== 32'h44443333) begin
      $display("FAIL pf_data: got %h want 44443333", rom_data); errors++;
    end
    if (sdram_req !== 1'b0) begin
      $display("FAIL pf_noreq: got %b want 0", sdram_req); errors++;
    end
  endtask
`endif

  initial begin
    rst       = 1'b0;
    rom_cs    = 1'b0;
    rom_addr  = '0;
    sdram_ack = 1'b0;
    data_dst  = 1'b0;
    data_rdy  = 1'b0;
    sdram_din = '0;
    rom_cs2   = 1'b0;
    rom_addr2 = '0;
    test_reset();
    test_fill();
    test_hold();
    test_addr_change();
    test_reset_midfetch();
    test_wrap();
`ifdef JTVIGIL_SCR2_PREFETCH_EN
    test_prefetch();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
